// File: rtl/riscv_spi_pkg.sv
// Shared constants for the SPI-hosted RV32I execute slot: SPI command codes,
// RV32I opcode/funct fields, the STATUS word layout and the SPI slave state type.
package riscv_spi_pkg;

  localparam logic [2:0] CMD_EXEC   = 3'b001;
  localparam logic [2:0] CMD_READ   = 3'b010;
  localparam logic [2:0] CMD_WRITE  = 3'b011;
  localparam logic [2:0] CMD_STATUS = 3'b100;

  localparam logic [5:0] SPI_CMD_LAST   = 6'd7;
  localparam logic [5:0] SPI_FRAME_LAST = 6'd39;
  localparam logic [5:0] SPI_FRAME_BITS = 6'd40;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef enum logic [1:0] {
    SPI_IDLE    = 2'd0,
    SPI_CMD     = 2'd1,
    SPI_PAYLOAD = 2'd2,
    SPI_DONE    = 2'd3
  } spi_state_e;

  // STATUS read word: {exec_count[15:0], 15'b0, illegal}
  function automatic logic [31:0] status_word(input logic [15:0] cnt, input logic ill);
    return {cnt, 15'b0, ill};
  endfunction

endpackage

// File: rtl/rv_spi_slave.sv
// SPI mode-0 slave: synchronises sclk/cs_n/mosi into clk, frames 8-bit cmd + 32-bit payload,
// and shifts a 32-bit read word out on miso from the 8th sclk fall. state_o exposes the FSM.
module rv_spi_slave
  import riscv_spi_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sclk_i,
  input  logic        cs_n_i,
  input  logic        mosi_i,
  input  logic [31:0] rd_word_i,
  output logic [7:0]  cmd_o,
  output logic [31:0] payload_o,
  output logic        frame_done_o,
  output logic        rd_load_o,
  output logic        miso_o,
  output logic [1:0]  state_o
);

  logic [2:0]  sclk_q;
  logic [1:0]  cs_n_q;
  logic [1:0]  mosi_q;
  logic [5:0]  bit_cnt_q;
  logic [31:0] shift_q;
  logic [7:0]  cmd_q;
  logic [31:0] tx_q;
  logic        miso_q;
  logic        frame_done_q;
  logic        rd_load_q;
  spi_state_e  state_q, state_d;

  logic cs_act, sclk_rise, sclk_fall, rise_take;

  // sclk_q[2] is the previous synchronised sample, used only for edge detection
  assign cs_act    = ~cs_n_q[1];
  assign sclk_rise =  sclk_q[1] & ~sclk_q[2];
  assign sclk_fall = ~sclk_q[1] &  sclk_q[2];
  assign rise_take = cs_act & sclk_rise & (bit_cnt_q < SPI_FRAME_BITS);

  always_comb begin
    state_d = state_q;
    if (!cs_act) begin
      state_d = SPI_IDLE;
    end else begin
      case (state_q)
        SPI_IDLE:    state_d = SPI_CMD;
        SPI_CMD:     if (rise_take && bit_cnt_q == SPI_CMD_LAST) state_d = SPI_PAYLOAD;
        SPI_PAYLOAD: if (rise_take && bit_cnt_q == SPI_FRAME_LAST) state_d = SPI_DONE;
        default:     state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sclk_q       <= 3'b000;
      cs_n_q       <= 2'b11;
      mosi_q       <= 2'b00;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      cmd_q        <= '0;
      tx_q         <= '0;
      miso_q       <= 1'b0;
      frame_done_q <= 1'b0;
      rd_load_q    <= 1'b0;
      state_q      <= SPI_IDLE;
    end else begin
      sclk_q       <= {sclk_q[1:0], sclk_i};
      cs_n_q       <= {cs_n_q[0], cs_n_i};
      mosi_q       <= {mosi_q[0], mosi_i};
      state_q      <= state_d;
      frame_done_q <= rise_take && (bit_cnt_q == SPI_FRAME_LAST);
      rd_load_q    <= rise_take && (bit_cnt_q == SPI_CMD_LAST);
      if (!cs_act) begin
        bit_cnt_q <= '0;
        miso_q    <= 1'b0;
      end else begin
        if (rise_take) begin
          shift_q   <= {shift_q[30:0], mosi_q[1]};
          bit_cnt_q <= bit_cnt_q + 6'd1;
          if (bit_cnt_q == SPI_CMD_LAST) cmd_q <= {shift_q[6:0], mosi_q[1]};
        end
        // the read word arrives one clk after the 8th rise, well before the 8th fall
        if (rd_load_q) tx_q <= rd_word_i;
        if (sclk_fall) begin
          if (bit_cnt_q > SPI_CMD_LAST && bit_cnt_q < SPI_FRAME_BITS) begin
            miso_q <= tx_q[31];
            tx_q   <= {tx_q[30:0], 1'b0};
          end else begin
            miso_q <= 1'b0;
          end
        end
      end
    end
  end

  assign cmd_o        = cmd_q;
  assign payload_o    = shift_q;
  assign frame_done_o = frame_done_q;
  assign rd_load_o    = rd_load_q;
  assign miso_o       = miso_q;
  assign state_o      = state_q;

endmodule

// File: rtl/riscv_spi_wrapper.sv
// Chip-slot top: SPI slave plus RV32I decoder, ALU and 32x32 register file.
// Define RVSPI_MUL_EN to accept MUL (funct7=0000001, funct3=000) on the OP opcode.
module riscv_spi_wrapper
  import riscv_spi_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  logic [7:0]  cmd;
  logic [31:0] payload;
  logic        frame_done;
  logic        rd_load;
  logic        miso;
  logic [1:0]  spi_state;
  logic [31:0] rd_word;

  logic [31:0] rf_q [32];
  logic [15:0] exec_cnt_q;
  logic        illegal_q;
  logic        wb_q;

  rv_spi_slave u_spi (
    .clk          (clk),
    .rst_n        (rst_n),
    .sclk_i       (ui_in[0]),
    .cs_n_i       (ui_in[1]),
    .mosi_i       (ui_in[2]),
    .rd_word_i    (rd_word),
    .cmd_o        (cmd),
    .payload_o    (payload),
    .frame_done_o (frame_done),
    .rd_load_o    (rd_load),
    .miso_o       (miso),
    .state_o      (spi_state)
  );

  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [4:0]  rd;
  logic [31:0] op_a, op_b, imm_i, alu_res;
  logic [4:0]  shamt;
  logic        legal;

  assign opcode = payload[6:0];
  assign rd     = payload[11:7];
  assign funct3 = payload[14:12];
  assign funct7 = payload[31:25];
  assign imm_i  = {{20{payload[31]}}, payload[31:20]};
  assign op_a   = rf_q[payload[19:15]];
  assign op_b   = (opcode == OPC_OP) ? rf_q[payload[24:20]] : imm_i;
  assign shamt  = op_b[4:0];

  always_comb begin
    alu_res = '0;
    legal   = 1'b0;
    case (funct3)
      F3_ADD:  alu_res = (opcode == OPC_OP && funct7 == F7_ALT) ? op_a - op_b : op_a + op_b;
      F3_SLL:  alu_res = op_a << shamt;
      F3_SLT:  alu_res = {31'b0, $signed(op_a) < $signed(op_b)};
      F3_SLTU: alu_res = {31'b0, op_a < op_b};
      F3_XOR:  alu_res = op_a ^ op_b;
      F3_SR:   alu_res = (funct7 == F7_ALT) ? $unsigned($signed(op_a) >>> shamt) : op_a >> shamt;
      F3_OR:   alu_res = op_a | op_b;
      default: alu_res = op_a & op_b;
    endcase
    case (opcode)
      OPC_LUI: begin
        legal   = 1'b1;
        alu_res = {payload[31:12], 12'b0};
      end
      OPC_OP_IMM: begin
        // only the shift-immediates constrain funct7; other OP-IMM forms use it as imm bits
        if (funct3 == F3_SLL)     legal = (funct7 == F7_BASE);
        else if (funct3 == F3_SR) legal = (funct7 == F7_BASE) || (funct7 == F7_ALT);
        else                      legal = 1'b1;
      end
      OPC_OP: begin
        if (funct7 == F7_BASE) begin
          legal = 1'b1;
        end else if (funct7 == F7_ALT) begin
          legal = (funct3 == F3_ADD) || (funct3 == F3_SR);
        end else if (funct7 == F7_MULDIV) begin
`ifdef RVSPI_MUL_EN
          if (funct3 == F3_ADD) begin
            legal   = 1'b1;
            alu_res = op_a * op_b;
          end
`else
          legal = 1'b0;
`endif
        end
      end
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    rd_word = '0;
    case (cmd[7:5])
      CMD_READ:   rd_word = rf_q[cmd[4:0]];
      CMD_STATUS: rd_word = status_word(exec_cnt_q, illegal_q);
      default:    rd_word = '0;
    endcase
  end

  // x0 is never written, so its storage stays at the reset value of zero
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
      exec_cnt_q <= '0;
      illegal_q  <= 1'b0;
      wb_q       <= 1'b0;
    end else begin
      wb_q <= frame_done;
      if (frame_done) begin
        case (cmd[7:5])
          CMD_WRITE: if (cmd[4:0] != 5'd0) rf_q[cmd[4:0]] <= payload;
          CMD_EXEC: begin
            if (legal) begin
              if (rd != 5'd0) rf_q[rd] <= alu_res;
              exec_cnt_q <= exec_cnt_q + 16'd1;
            end else begin
              illegal_q <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign uo_out  = {5'b0, illegal_q, frame_done | wb_q, miso};
  assign uio_out = 8'h00;
  assign uio_oe  = 8'h00;

  logic unused_ok;
  assign unused_ok = &{1'b0, ena, uio_in, ui_in[7:3], rd_load, spi_state};

endmodule

// File: tb/tb_riscv_spi_wrapper.sv
// Bench for riscv_spi_wrapper: directed register/exec scenarios plus randomized
// WRITE/EXEC/READ/STATUS traffic checked against a mnemonic-level RV32I model.
module tb_riscv_spi_wrapper;

  localparam int HALF = 4;
  localparam logic [7:0] C_EXEC   = 8'h20;
  localparam logic [7:0] C_READ   = 8'h40;
  localparam logic [7:0] C_WRITE  = 8'h60;
  localparam logic [7:0] C_STATUS = 8'h80;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic       sclk = 1'b0, cs_n = 1'b1, mosi = 1'b0;
  logic [7:0] ui_in, uo_out, uio_in, uio_out, uio_oe;

  int checks = 0;
  int errors = 0;

  logic [31:0] rf_m [32];
  logic [15:0] cnt_m;
  bit          ill_m;

  assign ui_in  = {5'b0, mosi, cs_n, sclk};
  assign uio_in = 8'h00;

  riscv_spi_wrapper dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uo_out  (uo_out),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  task automatic model_reset();
    for (int i = 0; i < 32; i++) rf_m[i] = 32'h0;
    cnt_m = 16'h0;
    ill_m = 1'b0;
  endtask

  function automatic logic [31:0] base_op(input logic [2:0] f3, input logic [31:0] a,
                                          input logic [31:0] b);
    case (f3)
      3'd0: return a + b;
      3'd1: return a << b[4:0];
      3'd2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd3: return (a < b) ? 32'd1 : 32'd0;
      3'd4: return a ^ b;
      3'd5: return a >> b[4:0];
      3'd6: return a | b;
      default: return a & b;
    endcase
  endfunction

  function automatic void model_exec(input logic [31:0] ins, output bit ok, output logic [31:0] res);
    logic [6:0]  op, f7;
    logic [2:0]  f3;
    logic [31:0] a, b;
    op = ins[6:0];
    f3 = ins[14:12];
    f7 = ins[31:25];
    a  = rf_m[ins[19:15]];
    b  = (op == 7'h33) ? rf_m[ins[24:20]] : {{20{ins[31]}}, ins[31:20]};
    ok = 1'b0;
    res = 32'h0;
    if (op == 7'h37) begin
      ok = 1'b1;
      res = {ins[31:12], 12'h000};
    end else if (op == 7'h13) begin
      res = base_op(f3, a, b);
      ok  = 1'b1;
      if (f3 == 3'd1) ok = (f7 == 7'h00);
      if (f3 == 3'd5) begin
        if (f7 == 7'h20) res = $signed(a) >>> b[4:0];
        else if (f7 != 7'h00) ok = 1'b0;
      end
    end else if (op == 7'h33) begin
      if (f7 == 7'h00) begin
        ok = 1'b1;
        res = base_op(f3, a, b);
      end else if (f7 == 7'h20 && f3 == 3'd0) begin
        ok = 1'b1;
        res = a - b;
      end else if (f7 == 7'h20 && f3 == 3'd5) begin
        ok = 1'b1;
        res = $signed(a) >>> b[4:0];
      end
`ifdef RVSPI_MUL_EN
      else if (f7 == 7'h01 && f3 == 3'd0) begin
        ok = 1'b1;
        res = a * b;
      end
`endif
    end
  endfunction

  // ---------------- driver tasks ----------------
  task automatic spi_xfer(input logic [7:0] cmd, input logic [31:0] pl, input int nbits,
                          input bit keep_cs, output logic [31:0] rd);
    logic [39:0] w;
    w  = {cmd, pl};
    rd = 32'h0;
    @(negedge clk);
    cs_n = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      mosi = w[39-i];
      repeat (HALF) @(negedge clk);
      if (i >= 8) rd = {rd[30:0], uo_out[0]};
      sclk = 1'b1;
      repeat (HALF) @(negedge clk);
      sclk = 1'b0;
    end
    repeat (HALF) @(negedge clk);
    if (!keep_cs) begin
      cs_n = 1'b1;
      mosi = 1'b0;
      repeat (8) @(negedge clk);
    end
  endtask

  task automatic do_write(input logic [4:0] r, input logic [31:0] v);
    logic [31:0] d;
    spi_xfer(C_WRITE | {3'b0, r}, v, 40, 1'b0, d);
    if (r != 5'd0) rf_m[r] = v;
  endtask

  task automatic do_exec(input logic [31:0] ins);
    logic [31:0] d, res;
    bit ok;
    model_exec(ins, ok, res);
    spi_xfer(C_EXEC, ins, 40, 1'b0, d);
    if (ok) begin
      if (ins[11:7] != 5'd0) rf_m[ins[11:7]] = res;
      cnt_m = cnt_m + 16'd1;
    end else begin
      ill_m = 1'b1;
    end
  endtask

  task automatic do_read(input logic [4:0] r, output logic [31:0] v);
    spi_xfer(C_READ | {3'b0, r}, $urandom, 40, 1'b0, v);
  endtask

  task automatic do_status(output logic [31:0] v);
    spi_xfer(C_STATUS, 32'h0, 40, 1'b0, v);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [31:0] v;
    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    checks++;
    if (uo_out !== 8'h00) begin errors++; $display("FAIL reset_uo_out got=%h exp=00", uo_out); end
    checks++;
    if (uio_oe !== 8'h00 || uio_out !== 8'h00) begin
      errors++; $display("FAIL reset_uio got oe=%h out=%h exp=00/00", uio_oe, uio_out);
    end
    do_read(5'd5, v);
    checks++;
    if (v !== 32'h0) begin errors++; $display("FAIL reset_read_x5 got=%h exp=00000000", v); end
    do_status(v);
    checks++;
    if (v !== 32'h0) begin errors++; $display("FAIL reset_status got=%h exp=00000000", v); end
  endtask

  task automatic test_write_exec();
    logic [31:0] v;
    do_write(5'd1, 32'h5);
    do_exec(32'hFFD08113);
    do_read(5'd2, v);
    checks++;
    if (v !== 32'h2) begin errors++; $display("FAIL addi_x2 got=%h exp=00000002", v); end
    do_status(v);
    checks++;
    if (v !== 32'h00010000) begin errors++; $display("FAIL addi_status got=%h exp=00010000", v); end
  endtask

  task automatic test_lui_x0();
    logic [31:0] v;
    do_exec(32'h123451B7);
    do_read(5'd3, v);
    checks++;
    if (v !== 32'h12345000) begin errors++; $display("FAIL lui_x3 got=%h exp=12345000", v); end
    do_exec(32'h00100013);
    do_read(5'd0, v);
    checks++;
    if (v !== 32'h0) begin errors++; $display("FAIL x0_write got=%h exp=00000000", v); end
    do_write(5'd0, 32'hDEADBEEF);
    do_read(5'd0, v);
    checks++;
    if (v !== 32'h0) begin errors++; $display("FAIL x0_spi_write got=%h exp=00000000", v); end
  endtask

  task automatic test_srai();
    logic [31:0] v;
    do_write(5'd1, 32'h80000000);
    do_exec(32'h4010D213);
    do_read(5'd4, v);
    checks++;
    if (v !== 32'hC0000000) begin errors++; $display("FAIL srai_x4 got=%h exp=c0000000", v); end
  endtask

  task automatic test_ecall();
    logic [31:0] v;
    logic [15:0] cnt_before;
    cnt_before = cnt_m;
    do_exec(32'h00000073);
    checks++;
    if (uo_out[2] !== 1'b1) begin errors++; $display("FAIL ecall_pin got=%b exp=1", uo_out[2]); end
    do_status(v);
    checks++;
    if (v !== {cnt_before, 15'b0, 1'b1}) begin
      errors++; $display("FAIL ecall_status got=%h exp=%h", v, {cnt_before, 15'b0, 1'b1});
    end
    for (int r = 1; r <= 4; r++) begin
      do_read(r[4:0], v);
      checks++;
      if (v !== rf_m[r]) begin errors++; $display("FAIL ecall_reg_x%0d got=%h exp=%h", r, v, rf_m[r]); end
    end
  endtask

  task automatic test_abort();
    logic [31:0] v;
    spi_xfer(C_WRITE | 8'd6, 32'hCAFEF00D, 20, 1'b0, v);
    do_read(5'd6, v);
    checks++;
    if (v !== 32'h0) begin errors++; $display("FAIL abort_x6 got=%h exp=00000000", v); end
    do_status(v);
    checks++;
    if (v !== {cnt_m, 15'b0, ill_m}) begin
      errors++; $display("FAIL abort_status got=%h exp=%h", v, {cnt_m, 15'b0, ill_m});
    end
  endtask

  task automatic test_mul();
    logic [31:0] v, exp;
    do_write(5'd1, 32'd7);
    do_write(5'd5, 32'd6);
    do_exec(32'h02508133);
`ifdef RVSPI_MUL_EN
    exp = 32'd42;
`else
    exp = rf_m[2];
`endif
    do_read(5'd2, v);
    checks++;
    if (v !== exp) begin errors++; $display("FAIL mul_x2 got=%h exp=%h", v, exp); end
  endtask

  task automatic test_random();
    logic [31:0] v, ins;
    logic [6:0]  op, f7;
    logic [4:0]  r;
    for (int n = 0; n < 36; n++) begin
      if ($urandom_range(0, 2) == 0) begin
        do_write($urandom_range(0, 7), $urandom);
      end else begin
        case ($urandom_range(0, 3))
          0: op = 7'h37;
          1: op = 7'h13;
          2: op = 7'h33;
          default: op = $urandom_range(0, 127);
        endcase
        case ($urandom_range(0, 3))
          0: f7 = 7'h00;
          1: f7 = 7'h20;
          2: f7 = 7'h01;
          default: f7 = $urandom_range(0, 127);
        endcase
        ins = {f7, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
               5'($urandom_range(0, 7)), op};
        do_exec(ins);
      end
      r = $urandom_range(0, 7);
      do_read(r, v);
      checks++;
      if (v !== rf_m[r]) begin errors++; $display("FAIL rand_read_x%0d iter=%0d got=%h exp=%h", r, n, v, rf_m[r]); end
      if (n % 4 == 3) begin
        do_status(v);
        checks++;
        if (v !== {cnt_m, 15'b0, ill_m}) begin
          errors++; $display("FAIL rand_status iter=%0d got=%h exp=%h", n, v, {cnt_m, 15'b0, ill_m});
        end
      end
      checks++;
      if (uo_out[2] !== ill_m) begin errors++; $display("FAIL rand_illegal_pin iter=%0d got=%b exp=%b", n, uo_out[2], ill_m); end
    end
  endtask

  task automatic test_midframe_reset();
    logic [31:0] v;
    do_write(5'd1, 32'h13572468);
    spi_xfer(C_WRITE | 8'd1, 32'hFFFFFFFF, 30, 1'b1, v);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    sclk = 1'b0;
    cs_n = 1'b1;
    mosi = 1'b0;
    rst_n = 1'b1;
    model_reset();
    repeat (4) @(negedge clk);
    checks++;
    if (uo_out !== 8'h00) begin errors++; $display("FAIL midreset_uo_out got=%h exp=00", uo_out); end
    do_read(5'd1, v);
    checks++;
    if (v !== 32'h0) begin errors++; $display("FAIL midreset_x1 got=%h exp=00000000", v); end
    do_status(v);
    checks++;
    if (v !== 32'h0) begin errors++; $display("FAIL midreset_status got=%h exp=00000000", v); end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_write_exec();
    test_lui_x0();
    test_srai();
    test_ecall();
    test_abort();
    test_mul();
    test_random();
    test_midframe_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
